gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
- Sequencer that drives the binary-to-Gray datapath through a programmable code range, up or down, with optional wrap.
- Delivers each Gray code word to a downstream consumer over a valid/ready handshake.
- Used wherever stepped Gray-coded indices are needed: pointer generators, encoder stimulus, position scanning.

Parameters:
- WIDTH, 4, width of the binary count and the Gray code.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
- stop  input  1  abort request; honoured in RUN.
- dir  input  1  0 = count up lo->hi, 1 = count down hi->lo; sampled at start.
- wrap  input  1  1 = restart the range after the end code; sampled at start.
- lo  input  WIDTH  lower range bound, inclusive; sampled at start.
- hi  input  WIDTH  upper range bound, inclusive; sampled at start.
- out_ready  input  1  consumer accepts the current word.
- out_valid  output  1  bin_out/gray_out hold a valid word.
- bin_out  output  WIDTH  current binary count (registered).
- gray_out  output  WIDTH  bin_out ^ (bin_out >> 1), combinational from the count register.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a non-wrapping sequence completes.
- cfg_err  output  1  one-cycle pulse when start is rejected because lo > hi.
- chk_err  output  1  sticky transition error flag; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state = IDLE. out_valid, bin_out, gray_out, busy, done, cfg_err and chk_err all = 0.
- States: IDLE, RUN, DONE.
- IDLE, start with lo <= hi:
  - Latch dir, wrap, lo, hi.
  - Count = lo if dir = 0, else hi.
  - Next state RUN; out_valid = 1 and busy = 1 from the next cycle (1-cycle start latency).
- IDLE, start with lo > hi: cfg_err = 1 for one cycle; remain in IDLE; count unchanged.
- start outside IDLE is ignored.
- RUN:
  - out_valid held at 1. bin_out and gray_out are stable while out_ready = 0.
  - A transfer occurs on out_valid & out_ready.
  - On transfer, if count != end code (hi when up, lo when down): count +1 (up) or -1 (down); the new word appears the next cycle, giving one word per cycle under constant ready.
  - On transfer of the end code with wrap = 1: reload the start code (lo up, hi down); stay in RUN.
  - On transfer of the end code with wrap = 0: next state DONE.
- lo == hi: single-word sequence, or the same word repeated when wrap = 1.
- stop in RUN:
  - Next state IDLE; out_valid and busy = 0 next cycle; bin_out held.
  - If a transfer happens in the same cycle it counts as completed; no further words are issued.
  - No done pulse.
- stop in IDLE or DONE is ignored.
- DONE: out_valid = 0, busy = 0, done = 1 for exactly one cycle, then IDLE. A start arriving during DONE is ignored.
- Full range (lo = 0, hi = 2^WIDTH - 1) with wrap: count wraps modulo 2^WIDTH with no overflow artefacts.
- Reset mid-sequence: immediate return to reset values. No sequence resumes without a new start.

Optional Feature:
- Macro: GRAY_SEQ_CHK_EN.
- Defined: an internal register stores the gray_out of the last transferred word.
  - On each non-reload transfer, the popcount of (previous Gray XOR current Gray) must equal 1. Otherwise chk_err sets and stays set until reset.
  - Reload steps (range restart) and the first word after start are exempt.
- Not defined: chk_err is tied to 0 and no checker logic is built.

Test Plan:
- lo=0, hi=15, dir=0, wrap=0, out_ready=1 -> 16 consecutive gray_out words 0000,0001,0011,0010,0110,...,1001,1000; done pulses 1 cycle after the last transfer; busy falls with it.
- lo=3, hi=5, up, out_ready toggled 0/1 each cycle -> gray_out held at 0010 while not ready; accepted sequence 0010,0110,0111, then done.
- lo=14, hi=15, dir=1, wrap=1, ready=1 -> bin_out 15,14,15,14,...; assert stop after 5 transfers -> out_valid=0 next cycle, no done pulse.
- start with lo=9, hi=4 -> cfg_err high 1 cycle, busy stays 0, out_valid stays 0.
- rst_n low while in RUN at bin_out=7 -> all outputs 0 without waiting for a clock edge; after release, stays IDLE until a new start.
- GRAY_SEQ_CHK_EN defined, lo=0, hi=15, wrap=1, 40 transfers -> chk_err stays 0; not defined -> chk_err is constant 0.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: steps a binary count through [lo, hi] (up or down, optional
// wrap) and presents each word plus its Gray code over a valid/ready handshake.
//
// Build option: define GRAY_SEQ_CHK_EN to build the Gray-step checker that
// drives chk_err; without it chk_err is tied low.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// RUN    | presenting words, advancing on each accepted transfer
// DONE   | one-cycle completion pulse, then back to IDLE
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             chk_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             dir_q, wrap_q;
  logic             cfg_err_q;

  logic             in_idle, in_run;
  logic             start_ok, start_bad;
  logic             xfer, at_end;
  logic [WIDTH-1:0] end_code, start_code;

  assign in_idle    = (state_q == S_IDLE);
  assign in_run     = (state_q == S_RUN);
  assign start_ok   = in_idle && start && (lo <= hi);
  assign start_bad  = in_idle && start && (lo > hi);
  assign xfer       = in_run && out_ready;
  assign end_code   = dir_q ? lo_q : hi_q;
  assign start_code = dir_q ? hi_q : lo_q;
  assign at_end     = (count_q == end_code);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; stop wins over end-of-sequence so an aborted run never pulses done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (stop)                         state_d = S_IDLE;
        else if (xfer && at_end && !wrap_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    out_valid = in_run;
    busy      = in_run;
    done      = (state_q == S_DONE);
  end

  // Configuration latch, count stepping and the rejected-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start_bad;
      if (start_ok) begin
        lo_q    <= lo;
        hi_q    <= hi;
        dir_q   <= dir;
        wrap_q  <= wrap;
        count_q <= dir ? hi : lo;
      end else if (xfer && !stop) begin
        if (at_end) begin
          if (wrap_q) count_q <= start_code;
        end else if (dir_q) begin
          count_q <= count_q - WIDTH'(1);
        end else begin
          count_q <= count_q + WIDTH'(1);
        end
      end
    end
  end

  assign bin_out  = count_q;
  assign gray_out = count_q ^ (count_q >> 1);
  assign cfg_err  = cfg_err_q;

`ifdef GRAY_SEQ_CHK_EN
  logic [WIDTH-1:0] prev_gray_q;
  logic             exempt_q;
  logic             chk_err_q;

  // Each accepted word must differ from the previous one in exactly one bit,
  // except the first word of a run and the word following a range reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      exempt_q    <= 1'b0;
      chk_err_q   <= 1'b0;
    end else if (start_ok) begin
      exempt_q <= 1'b1;
    end else if (xfer) begin
      prev_gray_q <= gray_out;
      exempt_q    <= at_end;
      if (!exempt_q && ($countones(prev_gray_q ^ gray_out) != 1)) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: directed scenarios plus randomized ranges, ready
// patterns and input disturbance, checked against an index-based model.
module tb_gray_seq_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0, stop = 1'b0, dir = 1'b0, wrap = 1'b0, out_ready = 1'b0;
  logic [W-1:0] lo = '0, hi = '0;
  logic         out_valid, busy, done, cfg_err, chk_err;
  logic [W-1:0] bin_out, gray_out;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .wrap(wrap),
    .lo(lo), .hi(hi), .out_ready(out_ready), .out_valid(out_valid),
    .bin_out(bin_out), .gray_out(gray_out), .busy(busy), .done(done),
    .cfg_err(cfg_err), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_lo, m_hi, m_dir, m_wrap, m_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // k-th word of the latched sequence, from plain range arithmetic.
  function automatic int exp_word(input int k);
    int n;
    int idx;
    n   = m_hi - m_lo + 1;
    idx = (m_wrap != 0) ? (k % n) : k;
    return (m_dir != 0) ? (m_hi - idx) : (m_lo + idx);
  endfunction

  function automatic logic [31:0] gray_of(input int b);
    logic [31:0] v;
    v = 32'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_seq(input int l, input int h, input int d, input int w);
    lo = W'(l); hi = W'(h); dir = (d != 0); wrap = (w != 0); start = 1'b1;
    tick();
    start = 1'b0;
    if (l <= h) begin
      m_lo = l; m_hi = h; m_dir = d; m_wrap = w; m_k = 0;
      chk("start_valid", out_valid, 1);
      chk("start_busy", busy, 1);
      chk("start_cfg_err", cfg_err, 0);
    end else begin
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_busy", busy, 0);
      chk("cfg_valid", out_valid, 0);
      tick();
      chk("cfg_err_clear", cfg_err, 0);
      chk("cfg_busy2", busy, 0);
      chk("cfg_valid2", out_valid, 0);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready toggles starting low.
  task automatic run_xfers(input int n, input int mode);
    int xf;
    int cyc;
    int r;
    xf = 0;
    cyc = 0;
    while (xf < n) begin
      if (cyc > 20 * n + 20) begin
        chk("xfer_timeout", 32'(xf), 32'(n));
        break;
      end
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("chk_err_low", chk_err, 0);
      chk("bin", bin_out, 32'(exp_word(m_k)));
      chk("gray", gray_out, gray_of(exp_word(m_k)));
      r = (mode == 0) ? 1 : (mode == 1) ? int'($urandom_range(0, 1)) : (cyc % 2);
      out_ready = (r != 0);
      lo = W'($urandom); hi = W'($urandom); dir = 1'($urandom); wrap = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      tick();
      cyc++;
      if (r != 0) begin
        xf++;
        m_k++;
      end
    end
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic expect_done();
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_bin_held", bin_out, 32'(exp_word(m_k - 1)));
    lo = 4'd0; hi = 4'd3; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("after_done_valid", out_valid, 0);
    tick();
    chk("start_in_done_ignored", out_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_stop(input logic rdy);
    stop = 1'b1;
    out_ready = rdy;
    tick();
    stop = 1'b0;
    out_ready = 1'b0;
    chk("stop_valid", out_valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_no_done", done, 0);
    chk("stop_bin_held", bin_out, 32'(exp_word(m_k)));
    tick();
    chk("stop_no_done2", done, 0);
    chk("stop_valid2", out_valid, 0);
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int l, h, d, n;
    #1 rst_n = 1'b0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_gray", gray_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_chk_err", chk_err, 0);
    rst_n = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_idle_ignored", busy, 0);

    // full range up, no wrap
    begin_seq(0, 15, 0, 0);
    run_xfers(16, 0);
    expect_done();

    // 3..5 up with ready toggling
    begin_seq(3, 5, 0, 0);
    run_xfers(3, 2);
    expect_done();

    // 14..15 down with wrap, stop after 5 transfers
    begin_seq(14, 15, 1, 1);
    run_xfers(5, 0);
    do_stop(1'b0);

    // rejected start
    begin_seq(9, 4, 0, 0);

    // async reset mid-run at bin_out = 7
    begin_seq(0, 15, 0, 0);
    run_xfers(7, 0);
    chk("pre_reset_bin", bin_out, 7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_bin", bin_out, 0);
    chk("async_rst_gray", gray_out, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_idle", out_valid, 0);
    chk("post_rst_bin", bin_out, 0);

    // full range wrap, 40 transfers with random ready, stop while transferring
    begin_seq(0, 15, 0, 1);
    run_xfers(40, 1);
    do_stop(1'b1);
    chk("chk_err_wrap", chk_err, 0);

    // single-word ranges
    begin_seq(6, 6, 1, 0);
    run_xfers(1, 1);
    expect_done();
    begin_seq(9, 9, 0, 1);
    run_xfers(4, 0);
    do_stop(1'b1);

    // random non-wrapping ranges run to completion
    for (int it = 0; it < 6; it++) begin
      l = int'($urandom_range(0, 15));
      h = int'($urandom_range(32'(l), 15));
      d = int'($urandom_range(0, 1));
      begin_seq(l, h, d, 0);
      run_xfers(h - l + 1, 1);
      expect_done();
    end

    // random wrapping ranges, stopped mid-way
    for (int it = 0; it < 4; it++) begin
      l = int'($urandom_range(0, 15));
      h = int'($urandom_range(32'(l), 15));
      d = int'($urandom_range(0, 1));
      n = 2 * (h - l + 1) + int'($urandom_range(0, 3));
      begin_seq(l, h, d, 1);
      run_xfers(n, 1);
      do_stop(1'($urandom));
    end

    // random rejected starts
    for (int it = 0; it < 3; it++) begin
      l = int'($urandom_range(1, 15));
      h = int'($urandom_range(0, 32'(l - 1)));
      begin_seq(l, h, int'($urandom_range(0, 1)), 0);
    end

    chk("final_chk_err", chk_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
